// File: rtl/dmem_store_buffer_pkg.sv
// Shared types for the data-memory store buffer.
// Entry layout, access-size codes and drain FSM states.
package riscv;

    localparam int XLEN = 32;

    localparam logic [2:0] SIZE_B = 3'b001;
    localparam logic [2:0] SIZE_H = 3'b010;
    localparam logic [2:0] SIZE_W = 3'b100;

    typedef struct packed {
        logic [XLEN-3:0] word_adr;
        logic [31:0]     wdata;
        logic [3:0]      be;
    } sb_entry_t;

    typedef enum logic {
        IDLE    = 1'b0,
        WR_PEND = 1'b1
    } sb_state_e;

endpackage

// File: rtl/sb_fifo.sv
// Store-buffer FIFO: wrap-bit pointers, entry storage and
// a parallel valid/word-address view for load-hit detection.
module sb_fifo
    import riscv::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            push,
    input  sb_entry_t                       push_entry,
    input  logic                            pop,
    output sb_entry_t                       head,
    output logic                            full,
    output logic                            empty,
    output logic [$clog2(DEPTH):0]          count,
    output logic [DEPTH-1:0]                valid,
    output logic [DEPTH-1:0][XLEN-3:0]      word_adr
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    sb_entry_t   entries [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            valid  <= '0;
        end else begin
            if (push) begin
                wr_ptr                 <= wr_ptr + 1'b1;
                valid[wr_ptr[AW-1:0]]  <= 1'b1;
            end
            if (pop) begin
                rd_ptr                 <= rd_ptr + 1'b1;
                valid[rd_ptr[AW-1:0]]  <= 1'b0;
            end
        end
    end

    // Payload needs no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[wr_ptr[AW-1:0]] <= push_entry;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            word_adr[i] = entries[i].word_adr;
        end
    end

    assign head  = entries[rd_ptr[AW-1:0]];
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/dmem_store_buffer.sv
// Data-memory store buffer: queues stores, drains them in the
// background and serves loads combinationally from the memory port.
module dmem_store_buffer
    import riscv::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            adr_v_i,
    input  logic [XLEN-1:0] adr_i,
    input  logic            is_store_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic [2:0]      access_size_i,
    output logic [XLEN-1:0] load_data_o,
    output logic            stall_o,
    output logic            misaligned_o,
    output logic            sb_empty_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_adr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [3:0]      mem_be_o,
    input  logic            mem_gnt_i,
    input  logic [XLEN-1:0] mem_rdata_i
);

    localparam int AW = $clog2(DEPTH);

    sb_state_e                  state;
    sb_entry_t                  head;
    sb_entry_t                  st_entry;
    logic                       full;
    logic                       empty;
    logic [AW:0]                count;
    logic [DEPTH-1:0]           valid;
    logic [DEPTH-1:0][XLEN-3:0] word_adr;

    logic       is_half;
    logic       is_word;
    logic       misaligned;
    logic       store_acc;
    logic       load_acc;
    logic       hit;
    logic       load_issue;
    logic       drain_req;
    logic       push;
    logic       pop;
    logic [3:0] st_be;
    logic [4:0] lane_sh;

    assign lane_sh = {adr_i[1:0], 3'b000};
    assign is_half = (access_size_i == SIZE_H);
    assign is_word = (access_size_i != SIZE_B) && !is_half;

    assign misaligned = adr_v_i &&
                        ((is_half && adr_i[0]) ||
                         (is_word && (adr_i[1:0] != 2'b00)));

    assign store_acc = adr_v_i && !misaligned && is_store_i;
    assign load_acc  = adr_v_i && !misaligned && !is_store_i;

    always_comb begin
        if (access_size_i == SIZE_B) begin
            st_be = 4'b0001 << adr_i[1:0];
        end else if (is_half) begin
            st_be = 4'b0011 << adr_i[1:0];
        end else begin
            st_be = 4'b1111;
        end
    end

    assign st_entry.word_adr = adr_i[XLEN-1:2];
    assign st_entry.wdata    = store_data_i << lane_sh;
    assign st_entry.be       = st_be;

    // The head being drained still counts as a hit.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (word_adr[i] == adr_i[XLEN-1:2])) begin
                hit = 1'b1;
            end
        end
    end

    assign load_issue = load_acc && !hit && (state == IDLE);
    assign drain_req  = !load_issue &&
                        ((state == WR_PEND) || (count != '0));
    assign pop        = drain_req && mem_gnt_i;
    // Full blocks the push even on a pop, keeping gnt off the stall path.
    assign push       = store_acc && !full;

    sb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (st_entry),
        .pop        (pop),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .valid      (valid),
        .word_adr   (word_adr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (drain_req && !mem_gnt_i) begin
                        state <= WR_PEND;
                    end
                end
                WR_PEND: begin
                    if (mem_gnt_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stall_o = (store_acc && full) ||
                     (load_acc && (hit || (state == WR_PEND) ||
                                   !mem_gnt_i));

    assign misaligned_o = misaligned;
    assign sb_empty_o   = empty && (state == IDLE);

    assign load_data_o = (load_issue && mem_gnt_i) ?
                         (mem_rdata_i >> lane_sh) : '0;

    assign mem_req_o   = load_issue || drain_req;
    assign mem_we_o    = drain_req;
    assign mem_adr_o   = load_issue ? {adr_i[XLEN-1:2], 2'b00} :
                                      {head.word_adr, 2'b00};
    assign mem_wdata_o = load_issue ? '0 : head.wdata;
    assign mem_be_o    = load_issue ? 4'b1111 : head.be;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed vector table plus multi-cycle sequences for the store buffer.
module tb_dmem_store_buffer;

    localparam logic [2:0] SB = 3'b001;
    localparam logic [2:0] SH = 3'b010;
    localparam logic [2:0] SW = 3'b100;

    logic        clk;
    logic        reset;
    logic        adr_v_i;
    logic [31:0] adr_i;
    logic        is_store_i;
    logic [31:0] store_data_i;
    logic [2:0]  access_size_i;
    logic [31:0] load_data_o;
    logic        stall_o;
    logic        misaligned_o;
    logic        sb_empty_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_adr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i;
    logic [31:0] mem_rdata_i;

    int checks;
    int failures;

    dmem_store_buffer #(
        .XLEN  (32),
        .DEPTH (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .adr_v_i       (adr_v_i),
        .adr_i         (adr_i),
        .is_store_i    (is_store_i),
        .store_data_i  (store_data_i),
        .access_size_i (access_size_i),
        .load_data_o   (load_data_o),
        .stall_o       (stall_o),
        .misaligned_o  (misaligned_o),
        .sb_empty_o    (sb_empty_o),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_adr_o     (mem_adr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_be_o      (mem_be_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rdata_i   (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        v;
        logic [31:0] a;
        logic        st;
        logic [31:0] d;
        logic [2:0]  sz;
        logic        gnt;
        logic [31:0] rd;
        logic        stall;
        logic        mis;
        logic        req;
        logic        we;
        logic [31:0] madr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] ld;
        logic        emp;
    } vec_t;

    vec_t vt [16];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [31:0] a,
                       input logic st, input logic [31:0] d,
                       input logic [2:0] sz, input logic gnt,
                       input logic [31:0] rd);
        adr_v_i       = v;
        adr_i         = a;
        is_store_i    = st;
        store_data_i  = d;
        access_size_i = sz;
        mem_gnt_i     = gnt;
        mem_rdata_i   = rd;
    endtask

    task automatic chk_vec(input vec_t e);
        chk({e.name, ".stall"}, 32'(stall_o), 32'(e.stall));
        chk({e.name, ".mis"}, 32'(misaligned_o), 32'(e.mis));
        chk({e.name, ".req"}, 32'(mem_req_o), 32'(e.req));
        chk({e.name, ".emp"}, 32'(sb_empty_o), 32'(e.emp));
        chk({e.name, ".ld"}, load_data_o, e.ld);
        if (e.req) begin
            chk({e.name, ".we"}, 32'(mem_we_o), 32'(e.we));
            chk({e.name, ".adr"}, mem_adr_o, e.madr);
            chk({e.name, ".be"}, 32'(mem_be_o), 32'(e.be));
            if (e.we) begin
                chk({e.name, ".wd"}, mem_wdata_o, e.wd);
            end
        end
    endtask

    logic [31:0] exp_adr [3];
    logic [31:0] exp_wd  [3];

    initial begin
        checks   = 0;
        failures = 0;

        //        name        v  a        st d             sz gnt rd
        //        stall mis req we madr  wd           be      ld          emp
        vt[0]  = '{"rst_idle", 0, 32'h0,   0, 32'h0,        SW, 1, 32'h0,
                   0, 0, 0, 0, 32'h0,   32'h0,        4'h0, 32'h0,       1};
        vt[1]  = '{"st_w100",  1, 32'h100, 1, 32'hDEADBEEF, SW, 1, 32'h0,
                   0, 0, 0, 0, 32'h0,   32'h0,        4'h0, 32'h0,       1};
        vt[2]  = '{"drain100", 0, 32'h0,   0, 32'h0,        SW, 1, 32'h0,
                   0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0,       0};
        vt[3]  = '{"empty1",   0, 32'h0,   0, 32'h0,        SW, 1, 32'h0,
                   0, 0, 0, 0, 32'h0,   32'h0,        4'h0, 32'h0,       1};
        vt[4]  = '{"st_b203",  1, 32'h203, 1, 32'hAB,       SB, 1, 32'h0,
                   0, 0, 0, 0, 32'h0,   32'h0,        4'h0, 32'h0,       1};
        vt[5]  = '{"drain200", 0, 32'h0,   0, 32'h0,        SW, 1, 32'h0,
                   0, 0, 1, 1, 32'h200, 32'hAB000000, 4'h8, 32'h0,       0};
        vt[6]  = '{"mis_h101", 1, 32'h101, 1, 32'h1234,     SH, 1, 32'h0,
                   0, 1, 0, 0, 32'h0,   32'h0,        4'h0, 32'h0,       1};
        vt[7]  = '{"mis_none", 0, 32'h0,   0, 32'h0,        SW, 1, 32'h0,
                   0, 0, 0, 0, 32'h0,   32'h0,        4'h0, 32'h0,       1};
        vt[8]  = '{"st_w300",  1, 32'h300, 1, 32'h55667788, SW, 0, 32'h0,
                   0, 0, 0, 0, 32'h0,   32'h0,        4'h0, 32'h0,       1};
        vt[9]  = '{"hit302a",  1, 32'h302, 0, 32'h0,        SH, 0, 32'h0,
                   1, 0, 1, 1, 32'h300, 32'h55667788, 4'hF, 32'h0,       0};
        vt[10] = '{"hit302b",  1, 32'h302, 0, 32'h0,        SH, 0, 32'h0,
                   1, 0, 1, 1, 32'h300, 32'h55667788, 4'hF, 32'h0,       0};
        vt[11] = '{"hit302c",  1, 32'h302, 0, 32'h0,        SH, 1, 32'h0,
                   1, 0, 1, 1, 32'h300, 32'h55667788, 4'hF, 32'h0,       0};
        vt[12] = '{"ld302",    1, 32'h302, 0, 32'h0,        SH, 1, 32'h11223344,
                   0, 0, 1, 0, 32'h300, 32'h0,        4'hF, 32'h00001122, 1};
        vt[13] = '{"ld_nognt", 1, 32'h302, 0, 32'h0,        SH, 0, 32'h11223344,
                   1, 0, 1, 0, 32'h300, 32'h0,        4'hF, 32'h0,       1};
        vt[14] = '{"mis_w102", 1, 32'h102, 0, 32'h0,        SW, 1, 32'h0,
                   0, 1, 0, 0, 32'h0,   32'h0,        4'h0, 32'h0,       1};
        vt[15] = '{"ld_b303",  1, 32'h303, 0, 32'h0,        SB, 1, 32'hA1B2C3D4,
                   0, 0, 1, 0, 32'h300, 32'h0,        4'hF, 32'h000000A1, 1};

        drv(0, 0, 0, 0, SW, 1, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drv(vt[i].v, vt[i].a, vt[i].st, vt[i].d, vt[i].sz,
                vt[i].gnt, vt[i].rd);
            #2;
            chk_vec(vt[i]);
        end

        // Fill to full with the port blocked, then release.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drv(1, 32'h400 + 32'(i * 4), 1, 32'(i + 1), SW, 0, 0);
            #2;
            chk($sformatf("fill%0d.stall", i), 32'(stall_o), 32'h0);
            if (i > 0) begin
                chk($sformatf("fill%0d.adr", i), mem_adr_o, 32'h400);
            end
        end
        @(negedge clk);
        drv(1, 32'h410, 1, 32'h5, SW, 0, 0);
        #2;
        chk("full.stall", 32'(stall_o), 32'h1);
        chk("full.req", 32'(mem_req_o), 32'h1);
        @(negedge clk);
        drv(1, 32'h410, 1, 32'h5, SW, 1, 0);
        #2;
        chk("full_pop.stall", 32'(stall_o), 32'h1);
        chk("full_pop.adr", mem_adr_o, 32'h400);
        chk("full_pop.wd", mem_wdata_o, 32'h1);
        @(negedge clk);
        drv(1, 32'h410, 1, 32'h5, SW, 1, 0);
        #2;
        chk("fifth.stall", 32'(stall_o), 32'h0);
        chk("fifth.adr", mem_adr_o, 32'h404);
        chk("fifth.wd", mem_wdata_o, 32'h2);
        exp_adr = '{32'h408, 32'h40C, 32'h410};
        exp_wd  = '{32'h3, 32'h4, 32'h5};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drv(0, 0, 0, 0, SW, 1, 0);
            #2;
            chk($sformatf("order%0d.req", i), 32'(mem_req_o), 32'h1);
            chk($sformatf("order%0d.adr", i), mem_adr_o, exp_adr[i]);
            chk($sformatf("order%0d.wd", i), mem_wdata_o, exp_wd[i]);
        end
        @(negedge clk);
        #2;
        chk("drained.req", 32'(mem_req_o), 32'h0);
        chk("drained.emp", 32'(sb_empty_o), 32'h1);

        // Reset while a write is pending with three entries queued.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drv(1, 32'h500 + 32'(i * 4), 1, 32'hC0 + 32'(i), SW, 0, 0);
        end
        @(negedge clk);
        drv(0, 0, 0, 0, SW, 0, 0);
        #2;
        chk("pend.req", 32'(mem_req_o), 32'h1);
        chk("pend.emp", 32'(sb_empty_o), 32'h0);
        reset = 1'b1;
        #1;
        chk("rst.req", 32'(mem_req_o), 32'h0);
        chk("rst.emp", 32'(sb_empty_o), 32'h1);
        chk("rst.stall", 32'(stall_o), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drv(0, 0, 0, 0, SW, 1, 0);
            #2;
            chk($sformatf("post_rst%0d.req", i), 32'(mem_req_o), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
